// File: rtl/return_stack_pkg.sv
// Shared constants for the return-address stack: address width and default depth.
package return_stack_pkg;

  localparam int ADDR_W      = 16;
  localparam int STACK_DEPTH = 8;

endpackage : return_stack_pkg

// File: rtl/return_stack_if.sv
// Control-unit <-> return-stack connection; pop_data feeds the program counter's load input.
interface return_stack_if
  import return_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
);

  // push/pop are single-cycle commands acted on at the next rising edge, with no
  // ready: a command the stack cannot honour is dropped and flagged in
  // overflow/underflow. pop_data is the live top of stack, valid whenever pop is high.
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             clr_err;
  logic [WIDTH-1:0] pop_data;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, push_data, clr_err,
    input  pop_data, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, clr_err,
    output pop_data, count, empty, full, overflow, underflow
  );

endinterface : return_stack_if

// File: rtl/return_stack_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module return_stack_ram
  import return_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are not reset; the stack pointer alone decides what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : return_stack_ram

// File: rtl/return_stack.sv
// Return-address LIFO: stack pointer, sticky error flags and the zero-when-empty pop_data mux.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int WIDTH = ADDR_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  return_stack_if.slave bus
);

  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             is_empty;
  logic             is_full;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] waddr;
  logic             we;
  logic [WIDTH-1:0] rdata;
  logic             ovf_set;
  logic             unf_set;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign top_idx  = count_q[PTR_W-1:0] - PTR_W'(1);

  // Push+pop on a non-empty stack overwrites the top in place (valid even when full).
  assign we      = bus.push && (!is_full || bus.pop);
  assign waddr   = (bus.push && bus.pop && !is_empty) ? top_idx : count_q[PTR_W-1:0];
  assign ovf_set = bus.push && !bus.pop && is_full;
  assign unf_set = bus.pop && is_empty;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && !bus.pop && !is_full) begin
        count_q <= count_q + CNT_W'(1);
      end else if (bus.pop && !bus.push && !is_empty) begin
        count_q <= count_q - CNT_W'(1);
      end else if (bus.push && bus.pop && is_empty) begin
        count_q <= CNT_W'(1);
      end
      // A new error in the same edge as clr_err keeps the flag set.
      overflow_q  <= ovf_set || (overflow_q && !bus.clr_err);
      underflow_q <= unf_set || (underflow_q && !bus.clr_err);
    end
  end

  return_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk   (CLK),
    .we    (we && RESET),
    .waddr (waddr),
    .wdata (bus.push_data),
    .raddr (top_idx),
    .rdata (rdata)
  );

  assign bus.pop_data  = is_empty ? '0 : rdata;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule : return_stack

// File: tb/tb_return_stack.sv
// Directed bench for return_stack: reset, LIFO order, overflow, underflow, replace-top, mid-burst reset.
module tb_return_stack;
  import return_stack_pkg::*;

  localparam int W = ADDR_W;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_top;

  return_stack_if #(.WIDTH(W), .DEPTH(STACK_DEPTH)) bus ();

  return_stack #(.WIDTH(W), .DEPTH(STACK_DEPTH)) u_dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step(input logic p_push, input logic p_pop, input logic [W-1:0] d,
                      input logic p_clr);
    bus.push      = p_push;
    bus.pop       = p_pop;
    bus.push_data = d;
    bus.clr_err   = p_clr;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic do_push(input logic [W-1:0] d);
    step(1'b1, 1'b0, d, 1'b0);
    exp_q.push_back(d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop: expected top comes from the bench's own queue
  task automatic pop_and_check(input string tag);
    exp_top = (exp_q.size() > 0) ? exp_q.pop_back() : '0;
    chk(tag, 32'(bus.pop_data), 32'(exp_top));
    step(1'b0, 1'b1, '0, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.push_data = '0;
    bus.clr_err   = 1'b0;

    // Reset held for two edges
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_unf", 32'(bus.underflow), 32'd0);
    chk("rst_pop_data", 32'(bus.pop_data), 32'h0000);
    rst_n = 1'b1;

    // LIFO order
    do_push(16'h6AB3);
    do_push(16'h87AB);
    do_push(16'h8400);
    chk("lifo_count", 32'(bus.count), 32'd3);
    chk("lifo_top", 32'(bus.pop_data), 32'h8400);
    pop_and_check("lifo_pop0");
    pop_and_check("lifo_pop1");
    pop_and_check("lifo_pop2");
    chk("lifo_empty", 32'(bus.empty), 32'd1);
    chk("lifo_pop_data0", 32'(bus.pop_data), 32'h0000);

    // Fill and overflow
    for (int i = 1; i <= 8; i++) do_push(W'(i));
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd8);
    step(1'b1, 1'b0, 16'h0009, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd8);
    chk("ovf_top", 32'(bus.pop_data), 32'h0008);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);

    // Replace-top while full
    step(1'b1, 1'b1, 16'hBEEF, 1'b0);
    void'(exp_q.pop_back());
    exp_q.push_back(16'hBEEF);
    chk("rep_count", 32'(bus.count), 32'd8);
    chk("rep_top", 32'(bus.pop_data), 32'hBEEF);
    chk("rep_ovf", 32'(bus.overflow), 32'd0);
    chk("rep_full", 32'(bus.full), 32'd1);

    // Drain: BEEF, 7, 6, ... 1
    for (int i = 0; i < 8; i++) pop_and_check($sformatf("drain%0d", i));
    chk("drain_empty", 32'(bus.empty), 32'd1);

    // Underflow
    step(1'b0, 1'b1, '0, 1'b0);
    chk("unf_count", 32'(bus.count), 32'd0);
    chk("unf_flag", 32'(bus.underflow), 32'd1);
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    chk("pp_empty_count", 32'(bus.count), 32'd1);
    chk("pp_empty_top", 32'(bus.pop_data), 32'h1234);
    chk("pp_empty_unf", 32'(bus.underflow), 32'd1);
    step(1'b0, 1'b1, '0, 1'b1);
    chk("clr_no_err_unf", 32'(bus.underflow), 32'd0);
    chk("clr_no_err_count", 32'(bus.count), 32'd0);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b1);
    chk("clr_vs_new_err", 32'(bus.underflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("unf_clr", 32'(bus.underflow), 32'd0);

    // Mid-operation reset beats a simultaneous push
    exp_q.delete();
    do_push(16'h000A);
    do_push(16'h000B);
    do_push(16'h000C);
    chk("mid_pre_count", 32'(bus.count), 32'd3);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    rst_n = 1'b1;
    exp_q.delete();
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_pop_data", 32'(bus.pop_data), 32'h0000);
    do_push(16'h5555);
    chk("post_rst_count", 32'(bus.count), 32'd1);
    chk("post_rst_top", 32'(bus.pop_data), 32'h5555);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_return_stack

// File: doc/return_stack.md
Name: return_stack

Overview:
- Hardware LIFO of return addresses for the calculator CPU's call/return flow.
- On a call, it captures the current program-counter value. On a return, it supplies that value to the program counter's load input while the counter's STACK_POP path is active.
- It sits between the control unit (which issues push/pop) and the program counter (which consumes pop_data).

Parameters:
- WIDTH, 16, address width; matches the program counter's in/out width.
- DEPTH, 8, number of stack entries; must be a power of 2 and at least 2.
- PTR_W, 3, log2(DEPTH); entry index width.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- push  input  1  write push_data as the new top entry this edge.
- pop  input  1  remove the top entry this edge.
- push_data  input  WIDTH  return address to store (the program counter's out).
- clr_err  input  1  clears the sticky error flags.
- pop_data  output  WIDTH  current top entry, combinational from the array and pointer; drives the program counter's in.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: a pop found no entry.

Behaviour:
- Reset (RESET low at the edge):
  - count=0, empty=1, full=0, overflow=0, underflow=0.
  - Array contents are don't-care.
  - pop_data=0 while empty.
  - Reset has priority over every other input, including mid-burst push/pop.
- Storage: array mem[0..DEPTH-1]; stack pointer sp = count. The top entry is mem[count-1].
- pop_data:
  - equals mem[count-1] when count>0, else 0;
  - is valid in the same cycle pop is asserted, so the program counter loads it on that same edge;
  - has zero latency.
- Push only: if not full, mem[count] <= push_data and count+1. If full, the push is ignored, state is unchanged and overflow is set.
- Pop only: if not empty, count-1. If empty, the pop is ignored and underflow is set.
- Push and pop together:
  - count>0: replace top; mem[count-1] <= push_data, count unchanged, no flag (valid when full).
  - count==0: the push is performed (count becomes 1) and underflow is set.
- Error flags:
  - Sticky until clr_err is high at an edge, or reset.
  - If clr_err and a new error occur in the same edge, the new error wins and the flag stays 1.
- Pointer arithmetic:
  - count is PTR_W+1 bits and never wraps.
  - Index arithmetic is mod DEPTH but is never exercised past the bounds.
- No internal FSM beyond the count register and the flags. Status outputs are combinational from count.

Decomposition:
- Shared package (calc_pkg): ADDR_W=16 constant and the default stack depth.
- One natural sub-module: stack_ram. It is a DEPTH x WIDTH register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- return_stack holds the pointer, the flag logic and the pop_data zero-mux.

Test Plan:
- Reset: hold RESET=0 for 2 edges -> count=0, empty=1, full=0, overflow=0, underflow=0, pop_data=0x0000.
- LIFO order: push 0x6AB3, 0x87AB, 0x8400 on three edges -> count=3, pop_data=0x8400. Then three pops -> pop_data 0x8400, 0x87AB, 0x6AB3 before each edge; finally empty=1, pop_data=0.
- Fill and overflow: push 0x0001..0x0008 -> full=1, count=8. Push 0x0009 -> count=8, pop_data=0x0008, overflow=1. Pulse clr_err -> overflow=0.
- Underflow: pop when empty -> count=0, underflow=1. Then push+pop together when empty with 0x1234 -> count=1, pop_data=0x1234, underflow stays 1.
- Replace-top: with count=8, push+pop with 0xBEEF -> count=8, pop_data=0xBEEF, overflow=0.
- Mid-operation reset: after 3 pushes, assert RESET=0 together with push=1 -> count=0, empty=1 next cycle, no entry written.
